// File: rtl/pong_game.sv
// Pong game logic and pixel generator: per-frame paddle/ball/score update
// during vertical blanking, registered one-clock pixel colour output.
module pong_game #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int BALL_SIZE    = 8,
    parameter int LEFT_X       = 16,
    parameter int RIGHT_X      = 616,
    parameter int PADDLE_STEP  = 4,
    parameter int BALL_SPEED   = 2,
    parameter int POINT_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hscan,
    input  logic [9:0] vscan,
    input  logic       btn_l_up,
    input  logic       btn_l_dn,
    input  logic       btn_r_up,
    input  logic       btn_r_dn,
    input  logic       serve,
    output logic       r,
    output logic       g,
    output logic       b,
    output logic [3:0] score_l,
    output logic [3:0] score_r
);
    typedef enum logic [1:0] {SERVE, PLAY, POINT, OVER} state_e;

    localparam logic [10:0] HA   = 11'(H_ACTIVE);
    localparam logic [10:0] VA   = 11'(V_ACTIVE);
    localparam logic [10:0] PW   = 11'(PADDLE_W);
    localparam logic [10:0] PH   = 11'(PADDLE_H);
    localparam logic [10:0] BS   = 11'(BALL_SIZE);
    localparam logic [10:0] LX   = 11'(LEFT_X);
    localparam logic [10:0] RX   = 11'(RIGHT_X);
    localparam logic [10:0] PS   = 11'(PADDLE_STEP);
    localparam logic [10:0] SP   = 11'(BALL_SPEED);
    localparam logic [10:0] PMAX = 11'(V_ACTIVE - PADDLE_H);
    localparam logic [10:0] CX   = 11'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [10:0] CY   = 11'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [10:0] NET0 = 11'(H_ACTIVE / 2 - 1);
    localparam logic [10:0] NET1 = 11'(H_ACTIVE / 2);
    localparam logic [3:0]  WIN  = 4'(WIN_SCORE);
    localparam int          CW   = $clog2(POINT_FRAMES + 1);
    localparam logic [CW-1:0] CLAST = CW'(POINT_FRAMES - 1);

    logic [4:0]    sync1_q, sync2_q;
    logic          tick_q;
    state_e        state_q, state_d;
    logic [10:0]   bx_q, bx_d, by_q, by_d;
    logic [10:0]   lpy_q, lpy_d, rpy_q, rpy_d;
    logic          dxr_q, dxr_d, dyd_q, dyd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    sl_q, sl_d, sr_q, sr_d;
    logic [2:0]    rgb_q, rgb_d;

    logic lu, ld, ru, rd, srv;
    assign {lu, ld, ru, rd, srv} = sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= {btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, serve};
            sync2_q <= sync1_q;
            tick_q  <= (hscan == 10'd0) && ({1'b0, vscan} == VA);
        end
    end

    function automatic logic [10:0] pad_move(input logic [10:0] y,
                                             input logic up,
                                             input logic dn);
        logic [10:0] res;
        res = y;
        if (up && !dn)
            res = (y < PS) ? 11'd0 : y - PS;
        else if (dn && !up)
            res = (y + PS > PMAX) ? PMAX : y + PS;
        return res;
    endfunction

    // Paddle overlap uses the paddle positions shown in the frame just ended.
    logic ov_l, ov_r, hit_l, hit_r;
    assign ov_l  = (by_q + BS > lpy_q) && (by_q < lpy_q + PH);
    assign ov_r  = (by_q + BS > rpy_q) && (by_q < rpy_q + PH);
    assign hit_l = !dxr_q && (bx_q >= LX + PW) && (bx_q <= LX + PW + SP) && ov_l;
    assign hit_r = dxr_q && (bx_q + BS >= RX - SP) && (bx_q + BS <= RX) && ov_r;

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        lpy_d   = lpy_q;
        rpy_d   = rpy_q;
        dxr_d   = dxr_q;
        dyd_d   = dyd_q;
        cnt_d   = cnt_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        if (tick_q) begin
            if (state_q != OVER) begin
                lpy_d = pad_move(lpy_q, lu, ld);
                rpy_d = pad_move(rpy_q, ru, rd);
            end
            unique case (state_q)
                SERVE: begin
                    bx_d = CX;
                    by_d = CY;
                    if (srv)
                        state_d = PLAY;
                end
                PLAY: begin
                    if (!dyd_q && by_q <= SP) begin
                        by_d  = 11'd0;
                        dyd_d = 1'b1;
                    end else if (dyd_q && by_q + BS + SP >= VA) begin
                        by_d  = VA - BS;
                        dyd_d = 1'b0;
                    end else begin
                        by_d = dyd_q ? by_q + SP : by_q - SP;
                    end
                    if (hit_l) begin
                        bx_d  = LX + PW;
                        dxr_d = 1'b1;
                    end else if (hit_r) begin
                        bx_d  = RX - BS;
                        dxr_d = 1'b0;
                    end else if (!dxr_q && bx_q < SP) begin
                        sr_d    = sr_q + 4'd1;
                        dxr_d   = 1'b0;
                        state_d = POINT;
                        cnt_d   = '0;
                        bx_d    = CX;
                        by_d    = CY;
                    end else if (dxr_q && bx_q + BS + SP > HA) begin
                        sl_d    = sl_q + 4'd1;
                        dxr_d   = 1'b1;
                        state_d = POINT;
                        cnt_d   = '0;
                        bx_d    = CX;
                        by_d    = CY;
                    end else begin
                        bx_d = dxr_q ? bx_q + SP : bx_q - SP;
                    end
                end
                POINT: begin
                    if (cnt_q == CLAST) begin
                        cnt_d   = '0;
                        state_d = (sl_q == WIN || sr_q == WIN) ? OVER : SERVE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                OVER: begin
                    if (srv) begin
                        sl_d    = 4'd0;
                        sr_d    = 4'd0;
                        state_d = SERVE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SERVE;
            bx_q    <= CX;
            by_q    <= CY;
            lpy_q   <= PMAX >> 1;
            rpy_q   <= PMAX >> 1;
            dxr_q   <= 1'b1;
            dyd_q   <= 1'b1;
            cnt_q   <= '0;
            sl_q    <= 4'd0;
            sr_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            lpy_q   <= lpy_d;
            rpy_q   <= rpy_d;
            dxr_q   <= dxr_d;
            dyd_q   <= dyd_d;
            cnt_q   <= cnt_d;
            sl_q    <= sl_d;
            sr_q    <= sr_d;
        end
    end

    logic [10:0] hx, vy;
    logic        active, hidden, in_ball, in_pad, in_net;
    assign hx      = {1'b0, hscan};
    assign vy      = {1'b0, vscan};
    assign active  = (hx < HA) && (vy < VA);
    assign hidden  = (state_q == POINT) || (state_q == OVER);
    assign in_ball = !hidden && hx >= bx_q && hx < bx_q + BS
                     && vy >= by_q && vy < by_q + BS;
    assign in_pad  = (hx >= LX && hx < LX + PW && vy >= lpy_q && vy < lpy_q + PH)
                     || (hx >= RX && hx < RX + PW && vy >= rpy_q && vy < rpy_q + PH);
    assign in_net  = (hx == NET0 || hx == NET1) && !vscan[3];

    always_comb begin
        rgb_d = 3'b000;
        if (!active)
            rgb_d = 3'b000;
        else if (in_ball)
            rgb_d = 3'b110;
        else if (in_pad)
            rgb_d = 3'b111;
        else if (in_net)
            rgb_d = 3'b001;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rgb_q <= 3'b000;
        else
            rgb_q <= rgb_d;
    end

    assign {r, g, b} = rgb_q;
    assign score_l   = sl_q;
    assign score_r   = sr_q;
endmodule

// File: tb/tb_pong_game.sv
// Randomised scoreboard bench for pong_game against a frame-level game model.
module tb_pong_game;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hscan, vscan;
    logic       btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, serve;
    logic       r, g, b;
    logic [3:0] score_l, score_r;

    pong_game dut (
        .clk(clk), .reset(rst_n), .hscan(hscan), .vscan(vscan),
        .btn_l_up(btn_l_up), .btn_l_dn(btn_l_dn),
        .btn_r_up(btn_r_up), .btn_r_dn(btn_r_dn), .serve(serve),
        .r(r), .g(g), .b(b), .score_l(score_l), .score_r(score_r)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int due;
        int exp;
        int x;
        int y;
    } exp_t;
    exp_t sb[$];
    int nchk = 0;
    int npass = 0;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            int   got;
            e = sb.pop_front();
            got = (e.kind == 0) ? int'({r, g, b}) : int'({score_l, score_r});
            nchk++;
            if (got == e.exp)
                npass++;
            else
                $display("FAIL %s x=%0d y=%0d cyc=%0d: got %0h expected %0h",
                         (e.kind == 0) ? "pixel" : "scores", e.x, e.y, cyc, got, e.exp);
        end
    end

    // Frame-level reference model
    typedef enum {M_SERVE, M_PLAY, M_POINT, M_OVER} mst_e;
    mst_e m_st;
    int   m_bx, m_by, m_lpy, m_rpy, m_sl, m_sr, m_cnt;
    bit   m_right, m_down;

    function automatic void model_reset();
        m_st = M_SERVE; m_bx = 316; m_by = 236; m_lpy = 208; m_rpy = 208;
        m_sl = 0; m_sr = 0; m_cnt = 0; m_right = 1; m_down = 1;
    endfunction

    function automatic int pad(input int y, input bit up, input bit dn);
        if (up && !dn) return (y < 4) ? 0 : y - 4;
        if (dn && !up) return (y + 4 > 416) ? 416 : y + 4;
        return y;
    endfunction

    function automatic void model_tick(input bit lu, ld, ru, rd, srv);
        int  olp, orp, nby;
        bit  ndown, lov, rov;
        olp = m_lpy;
        orp = m_rpy;
        if (m_st != M_OVER) begin
            m_lpy = pad(m_lpy, lu, ld);
            m_rpy = pad(m_rpy, ru, rd);
        end
        case (m_st)
            M_SERVE: if (srv) m_st = M_PLAY;
            M_PLAY: begin
                ndown = m_down;
                if (!m_down && m_by <= 2) begin nby = 0; ndown = 1; end
                else if (m_down && m_by + 10 >= 480) begin nby = 472; ndown = 0; end
                else nby = m_down ? m_by + 2 : m_by - 2;
                lov = (m_by + 8 > olp) && (m_by < olp + 64);
                rov = (m_by + 8 > orp) && (m_by < orp + 64);
                if (!m_right) begin
                    if (m_bx >= 24 && m_bx <= 26 && lov) begin m_bx = 24; m_right = 1; end
                    else if (m_bx < 2) begin
                        m_sr++; m_st = M_POINT; m_cnt = 0; m_bx = 316; m_by = 236;
                    end else m_bx -= 2;
                end else begin
                    if (m_bx + 8 >= 614 && m_bx + 8 <= 616 && rov) begin m_bx = 608; m_right = 0; end
                    else if (m_bx + 10 > 640) begin
                        m_sl++; m_right = 1; m_st = M_POINT; m_cnt = 0; m_bx = 316; m_by = 236;
                    end else m_bx += 2;
                end
                m_down = ndown;
                if (m_st == M_PLAY) m_by = nby;
            end
            M_POINT: begin
                m_cnt++;
                if (m_cnt == 60) begin
                    m_cnt = 0;
                    m_st = (m_sl == 9 || m_sr == 9) ? M_OVER : M_SERVE;
                end
            end
            M_OVER: if (srv) begin m_sl = 0; m_sr = 0; m_st = M_SERVE; end
            default: ;
        endcase
    endfunction

    function automatic bit inside_rect(int x, int y, int rx, int ry, int w, int h);
        return x >= rx && x < rx + w && y >= ry && y < ry + h;
    endfunction

    function automatic int render(input int x, input int y);
        if (x >= 640 || y >= 480) return 0;
        if (m_st != M_POINT && m_st != M_OVER && inside_rect(x, y, m_bx, m_by, 8, 8)) return 6;
        if (inside_rect(x, y, 16, m_lpy, 8, 64) || inside_rect(x, y, 616, m_rpy, 8, 64)) return 7;
        if ((x == 319 || x == 320) && ((y / 8) % 2 == 0)) return 1;
        return 0;
    endfunction

    task automatic probe(input int x, input int y);
        exp_t e;
        if (x < 0 || y < 0 || x > 1023 || y > 1023 || (x == 0 && y == 480)) return;
        hscan = 10'(x);
        vscan = 10'(y);
        e.kind = 0; e.due = cyc + 1; e.exp = render(x, y); e.x = x; e.y = y;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic check_scores_at(input int due);
        exp_t e;
        e.kind = 1; e.due = due; e.exp = m_sl * 16 + m_sr; e.x = -1; e.y = -1;
        sb.push_back(e);
    endtask

    int px[17] = '{316, 323, 315, 324, 316, 16, 23, 24, 16, 616, 623, 615, 640, 100, 319, 320, 319};
    int py[17] = '{236, 243, 236, 240, 244, 208, 271, 240, 272, 208, 271, 208, 100, 480, 0, 8, 16};

    task automatic probe_scene();
        for (int i = 0; i < 17; i++) probe(px[i], py[i]);
    endtask

    task automatic frame_probes();
        int r0, r1;
        r0 = int'($urandom_range(7));
        r1 = int'($urandom_range(7));
        probe(m_bx + r0, m_by + r1);
        case ($urandom_range(3))
            0: probe(m_bx - 1, m_by + r1);
            1: probe(m_bx + 8, m_by + r1);
            2: probe(m_bx + r0, m_by - 1);
            default: probe(m_bx + r0, m_by + 8);
        endcase
        if ($urandom_range(1) == 1)
            probe(15 + int'($urandom_range(9)), m_lpy - 1 + int'($urandom_range(65)));
        else
            probe(615 + int'($urandom_range(9)), m_rpy - 1 + int'($urandom_range(65)));
        probe(int'($urandom_range(799)), int'($urandom_range(524)));
    endtask

    task automatic do_frame(input bit lu, ld, ru, rd, srv);
        int c;
        @(posedge clk); #1;
        {btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, serve} = {lu, ld, ru, rd, srv};
        hscan = 10'd700; vscan = 10'd500;
        repeat (3) @(posedge clk);
        #1;
        hscan = 10'd0; vscan = 10'd480; c = cyc;
        @(posedge clk); #1;
        hscan = 10'd700; vscan = 10'd500;
        model_tick(lu, ld, ru, rd, srv);
        check_scores_at(c + 2);
        @(posedge clk); #1;
        frame_probes();
    endtask

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int frames;
        bit lu, ld, ru, rd;
        rst_n = 1'b0;
        {btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, serve} = '0;
        hscan = 10'd100; vscan = 10'd100;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        m_sl = 0; m_sr = 0;
        check_scores_at(cyc);
        @(posedge clk); #1;
        rst_n = 1'b1;
        probe_scene();

        // left paddle driven to the top, then both left buttons together
        for (int i = 0; i < 60; i++) do_frame(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) do_frame(1, 1, 0, 1, 0);
        do_frame(0, 0, 0, 0, 1);

        for (int i = 0; i < 300; i++)
            do_frame($urandom_range(1) == 1, $urandom_range(1) == 1,
                     $urandom_range(1) == 1, $urandom_range(1) == 1,
                     $urandom_range(3) == 0);

        // reset while the previous pixel was the ball
        @(posedge clk); #1;
        hscan = 10'(m_bx); vscan = 10'(m_by);
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        begin
            exp_t e;
            e.kind = 0; e.due = cyc; e.exp = 0; e.x = m_bx; e.y = m_by;
            sb.push_back(e);
        end
        check_scores_at(cyc);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hscan = 10'd700; vscan = 10'd500;
        @(posedge clk); #1;
        probe_scene();

        // left tracks the ball, right dodges it, until the game ends
        frames = 0;
        while (m_st != M_OVER && frames < 3500) begin
            lu = (m_by + 4 < m_lpy + 30);
            ld = (m_by + 4 > m_lpy + 34);
            rd = (m_by + 4 < m_rpy + 32);
            ru = !rd;
            do_frame(lu, ld, ru, rd, m_st == M_SERVE);
            frames++;
        end
        if (m_st != M_OVER) begin
            nchk++;
            $display("FAIL game_over_timeout: state %0d after %0d frames, required GAME_OVER",
                     m_st, frames);
        end

        for (int i = 0; i < 65; i++)
            do_frame($urandom_range(1) == 1, $urandom_range(1) == 1,
                     $urandom_range(1) == 1, $urandom_range(1) == 1, 0);
        do_frame(0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++)
            do_frame($urandom_range(1) == 1, $urandom_range(1) == 1,
                     $urandom_range(1) == 1, $urandom_range(1) == 1, 1);

        repeat (5) @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
            nchk += sb.size();
        end
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
